// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the shared UART arbiter
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            i_Req_Valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data;
   logic [NUM_REQ-1:0]            o_Req_Ack;
   logic [NUM_REQ-1:0]            o_Req_Done;
   logic                          o_Tx_DV;
   logic [DATA_WIDTH-1:0]         o_Tx_Data;
   logic                          i_Tx_Active;
   logic                          i_Tx_Done;
   logic [$clog2(NUM_REQ)-1:0]    o_Grant_Id;
   logic                          o_Busy;
   logic                          o_Timeout;
   modport master (
      input  i_Req_Valid, i_Req_Data, i_Tx_Active, i_Tx_Done,
      output o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Data, o_Grant_Id, o_Busy, o_Timeout
   );
   modport slave (
      output i_Req_Valid, i_Req_Data, i_Tx_Active, i_Tx_Done,
      input  o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Data, o_Grant_Id, o_Busy, o_Timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ byte producers, with watchdog
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic i_Clock,
   input logic i_Rst_n,
   uart_tx_arbiter_if.master bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {RESYNC, IDLE, WAIT_ACTIVE, WAIT_DONE, RELEASE} state_t;

   state_t                state_q, state_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d, done_q, done_d;
   logic                  dv_q, dv_d, to_q, to_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IW-1:0]         grant_q, grant_d, sel, idx;
   logic [WW-1:0]         wd_q, wd_d;
   logic                  found, waiting, expire;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= RESYNC;
         ack_q   <= '0;
         done_q  <= '0;
         dv_q    <= 1'b0;
         to_q    <= 1'b0;
         data_q  <= '0;
         grant_q <= IW'(NUM_REQ - 1);
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         dv_q    <= dv_d;
         to_q    <= to_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         wd_q    <= wd_d;
      end
   end

   // first valid requester searching upward from the one after the last grant
   always_comb begin
      sel   = grant_q;
      idx   = grant_q;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IW'((int'(grant_q) + i) % NUM_REQ);
         if (!found && bus.i_Req_Valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign waiting = (state_q == WAIT_ACTIVE) || (state_q == WAIT_DONE);
   assign expire  = waiting && (wd_q == WW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         RESYNC:      state_d = (!bus.i_Tx_Active && !bus.i_Tx_Done) ? IDLE : RESYNC;
         IDLE:        state_d = found ? WAIT_ACTIVE : IDLE;
         WAIT_ACTIVE: state_d = expire ? RESYNC : bus.i_Tx_Active ? WAIT_DONE : WAIT_ACTIVE;
         WAIT_DONE:   state_d = expire ? RESYNC : bus.i_Tx_Done ? RELEASE : WAIT_DONE;
         RELEASE:     state_d = bus.i_Tx_Done ? RELEASE : IDLE;
         default:     state_d = RESYNC;
      endcase
   end

   always_comb begin
      dv_d    = (state_q == IDLE) && found;
      ack_d   = dv_d ? NUM_REQ'(1) << sel : '0;
      done_d  = (state_q == WAIT_DONE && bus.i_Tx_Done && !expire) ? NUM_REQ'(1) << grant_q : '0;
      data_d  = dv_d ? bus.i_Req_Data[sel*DATA_WIDTH +: DATA_WIDTH] : data_q;
      grant_d = dv_d ? sel : grant_q;
      wd_d    = dv_d ? '0 : (waiting && wd_q != '1) ? wd_q + 1'b1 : wd_q;
      to_d    = expire;
   end

   assign bus.o_Req_Ack  = ack_q;
   assign bus.o_Req_Done = done_q;
   assign bus.o_Tx_DV    = dv_q;
   assign bus.o_Tx_Data  = data_q;
   assign bus.o_Grant_Id = grant_q;
   assign bus.o_Busy     = state_q != IDLE;
   assign bus.o_Timeout  = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural uart_tx (CLKS_PER_BIT=4) on the transmitter side
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 48;
   localparam int C  = 4;
   localparam int F  = 10 * C;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();
   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_Clock(clk),
      .i_Rst_n(rst_n),
      .bus(bus)
   );

   // transmitter model: no reset, active for 10 bit times, done held for 2 cycles
   int       tx_p    = 0;
   logic [7:0] tx_byte = '0;
   bit       tx_dead = 1'b0;
   logic     tx_serial;
   always @(posedge clk)
      if (tx_p == 0) begin
         if (bus.o_Tx_DV && !tx_dead) begin
            tx_p    <= 1;
            tx_byte <= bus.o_Tx_Data;
         end
      end else tx_p <= (tx_p == F + 2) ? 0 : tx_p + 1;
   assign bus.i_Tx_Active = (tx_p >= 1) && (tx_p <= F);
   assign bus.i_Tx_Done   = (tx_p == F + 1) || (tx_p == F + 2);
   always_comb tx_serial = (tx_p >= 1 && tx_p <= C) ? 1'b0 :
                           (tx_p > C && tx_p <= 9 * C) ? tx_byte[3'((tx_p - C - 1) / C)] : 1'b1;

   int checks = 0;
   int passes = 0;
   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct packed {logic [1:0] id; logic [7:0] d;} ev_t;
   ev_t        dv_q[$];
   int         done_q[$];
   logic [7:0] ser_q[$];
   int         to_n = 0;

   int cyc = 0;
   int last_dv = 0;
   int last_done = -1;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      if (bus.o_Tx_DV || bus.o_Req_Ack != 0) begin
         if (dv_q.size() == 0) chk(1'b0, "unexpected_grant", bus.o_Req_Ack, 0);
         else begin
            ev_t e;
            logic [3:0] oh;
            e  = dv_q.pop_front();
            oh = 4'd1 << e.id;
            chk(bus.o_Tx_DV && bus.o_Req_Ack == oh && bus.o_Grant_Id == e.id && bus.o_Tx_Data == e.d,
                "grant", {bus.o_Tx_DV, bus.o_Req_Ack, bus.o_Grant_Id, bus.o_Tx_Data},
                {1'b1, oh, e.id, e.d});
         end
         if (last_done > last_dv) chk(cyc - last_done >= 3, "done_to_dv_gap", cyc - last_done, 3);
         last_dv = cyc;
      end
      if (bus.o_Req_Done != 0) begin
         if (done_q.size() == 0) chk(1'b0, "unexpected_done", bus.o_Req_Done, 0);
         else begin
            int id;
            logic [3:0] oh;
            id = done_q.pop_front();
            oh = 4'd1 << id;
            chk(bus.o_Req_Done == oh && bus.o_Grant_Id == 2'(id), "done_id", bus.o_Req_Done, oh);
            chk(cyc - last_dv == F + 2, "done_latency", cyc - last_dv, F + 2);
         end
         last_done = cyc;
      end
      if (bus.o_Timeout) begin
         if (to_n == 0) chk(1'b0, "unexpected_timeout", 1, 0);
         else begin
            to_n--;
            chk(cyc - last_dv == TO, "timeout_latency", cyc - last_dv, TO);
            chk(bus.o_Req_Done == 0, "timeout_no_done", bus.o_Req_Done, 0);
         end
      end
   end

   // serial line decoder: samples the middle of each bit of every real frame
   initial forever begin
      logic [9:0] fr;
      @(negedge clk iff bus.o_Tx_DV);
      if (!tx_dead) begin
         repeat (2) @(negedge clk);
         fr[0] = tx_serial;
         for (int b = 1; b < 10; b++) begin
            repeat (C) @(negedge clk);
            fr[b] = tx_serial;
         end
         if (ser_q.size() == 0) chk(1'b0, "unexpected_frame", fr, 0);
         else begin
            logic [7:0] eb;
            eb = ser_q.pop_front();
            chk(fr == {1'b1, eb, 1'b0}, "serial_frame", fr, {1'b1, eb, 1'b0});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected 0", 1);
      $fatal(1);
   end

   task automatic chk_reset();
      chk(bus.o_Req_Ack == 0 && bus.o_Req_Done == 0 && !bus.o_Tx_DV && bus.o_Tx_Data == 0 && !bus.o_Timeout,
          "reset_outputs", {bus.o_Req_Ack, bus.o_Req_Done, bus.o_Tx_DV, bus.o_Tx_Data, bus.o_Timeout}, 0);
      chk(bus.o_Grant_Id == 2'd3, "reset_grant", bus.o_Grant_Id, 3);
      chk(bus.o_Busy, "reset_busy", bus.o_Busy, 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (bus.o_Busy && t < 300);
      chk(!bus.o_Busy, "idle_wait", bus.o_Busy, 0);
   endtask

   task automatic run(input logic [3:0] m, input bit keep, input int n, output int lat);
      int cnt = 0;
      int t = 0;
      lat = -1;
      bus.i_Req_Valid = m;
      while (cnt < n && t < 400) begin
         @(negedge clk);
         t++;
         if (bus.o_Req_Ack != 0) begin
            cnt++;
            if (lat < 0) lat = t;
            if (!keep) bus.i_Req_Valid = bus.i_Req_Valid & ~bus.o_Req_Ack;
         end
      end
      bus.i_Req_Valid = '0;
      chk(cnt == n, "ack_count", cnt, n);
      wait_idle();
   endtask

   task automatic push(input int id, input logic [7:0] d, input bit real_tx);
      dv_q.push_back({2'(id), d});
      if (real_tx) begin
         done_q.push_back(id);
         ser_q.push_back(d);
      end
   endtask

   initial begin
      int lat;
      int t;
      bus.i_Req_Valid = '0;
      bus.i_Req_Data  = '0;
      @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk(!bus.o_Busy, "resync_to_idle", bus.o_Busy, 0);

      // single requester
      bus.i_Req_Data = {8'h00, 8'hA5, 8'h00, 8'h00};
      push(2, 8'hA5, 1'b1);
      run(4'b0100, 1'b0, 1, lat);
      chk(lat == 1, "grant_latency", lat, 1);
      chk(bus.o_Grant_Id == 2'd2, "grant_id_held", bus.o_Grant_Id, 2);

      // round-robin from a fresh pointer
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int k = 0; k < 5; k++) push(k % 4, 8'h10 + 8'(k % 4), 1'b1);
      run(4'b1111, 1'b1, 5, lat);

      // wrap-around
      bus.i_Req_Data = {8'h33, 8'h00, 8'h00, 8'h00};
      push(3, 8'h33, 1'b1);
      run(4'b1000, 1'b0, 1, lat);
      bus.i_Req_Data = {8'h43, 8'h00, 8'h41, 8'h00};
      push(1, 8'h41, 1'b1);
      push(3, 8'h43, 1'b1);
      run(4'b1010, 1'b0, 2, lat);

      // watchdog: transmitter never goes active
      tx_dead = 1'b1;
      bus.i_Req_Data = {8'h00, 8'h77, 8'h00, 8'h00};
      push(2, 8'h77, 1'b0);
      to_n++;
      run(4'b0100, 1'b0, 1, lat);
      tx_dead = 1'b0;
      bus.i_Req_Data = {8'h83, 8'h82, 8'h00, 8'h00};
      push(3, 8'h83, 1'b1);
      push(2, 8'h82, 1'b1);
      run(4'b1100, 1'b0, 2, lat);

      // reset during data bit 3
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus.i_Req_Data = {8'h00, 8'h00, 8'h3C, 8'h00};
      dv_q.push_back({2'd1, 8'h3C});
      ser_q.push_back(8'h3C);
      bus.i_Req_Valid = 4'b0010;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (bus.o_Req_Ack == 0 && t < 10);
      bus.i_Req_Valid = '0;
      chk(bus.o_Req_Ack == 4'b0010, "midframe_ack", bus.o_Req_Ack, 4'b0010);
      t = 0;
      while (tx_p != C + 3 * C + 2 && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk(tx_p == C + 3 * C + 2, "reach_bit3", tx_p, C + 3 * C + 2);
      rst_n = 1'b0;
      #1;
      chk_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      while (tx_p != F + 1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk(bus.o_Busy, "resync_hold_done", bus.o_Busy, 1);
      t = 0;
      while (tx_p != 0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk(bus.o_Busy, "resync_last_cycle", bus.o_Busy, 1);
      @(negedge clk);
      chk(!bus.o_Busy, "resync_exit", bus.o_Busy, 0);
      bus.i_Req_Data = {8'h00, 8'h00, 8'h00, 8'hE1};
      push(0, 8'hE1, 1'b1);
      run(4'b0001, 1'b0, 1, lat);
      chk(lat == 1, "post_reset_latency", lat, 1);

      repeat (4) @(negedge clk);
      chk(dv_q.size() == 0, "grants_outstanding", dv_q.size(), 0);
      chk(done_q.size() == 0, "dones_outstanding", done_q.size(), 0);
      chk(ser_q.size() == 0, "frames_outstanding", ser_q.size(), 0);
      chk(to_n == 0, "timeouts_outstanding", to_n, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
